// File: rtl/store_queue_pkg.sv
// Shared constants and the buffered-entry layout for the store queue.
package store_pkg;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } st_funct3_e;

  // Entry fields are sized for a 32-bit datapath.
  localparam int unsigned ENTRY_XLEN = 32;
  localparam int unsigned ENTRY_NB   = ENTRY_XLEN / 8;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] addr;
    logic [ENTRY_XLEN-1:0] wdata;
    logic [ENTRY_NB-1:0]   wstrb;
  } sq_entry_t;

endpackage

// File: rtl/store_queue_if.sv
// Pipeline-side store request channel and memory-side write channel.
interface store_req_if #(
  parameter int XLEN = 32
);
  logic            st_valid;
  logic            st_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] st_addr;
  logic [XLEN-1:0] st_data;
  logic            st_err;

  modport master (output st_valid, opcode, funct3, st_addr, st_data,
                  input  st_ready, st_err);
  modport slave  (input  st_valid, opcode, funct3, st_addr, st_data,
                  output st_ready, st_err);
endinterface

interface store_mem_if #(
  parameter int XLEN = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready);
endinterface

// File: rtl/store_queue_format.sv
// Decodes a store request into lane-replicated data and byte strobes.
module store_format
  import store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] wstrb,
  output logic              legal,
  output logic              misaligned
);

  localparam int NB = XLEN / 8;

  // Width select: replicate the narrow datum to every lane, strobe only the target lanes.
  always_comb begin
    wdata      = '0;
    wstrb      = '0;
    legal      = 1'b0;
    misaligned = 1'b0;
    if (opcode == OP_STORE) begin
      case (funct3)
        F3_SB: begin
          legal = 1'b1;
          wdata = {NB{data[7:0]}};
          wstrb = NB'(1) << addr[1:0];
        end
        F3_SH: begin
          legal      = 1'b1;
          wdata      = {(NB/2){data[15:0]}};
          wstrb      = NB'(3) << {addr[1], 1'b0};
          misaligned = addr[0];
        end
        F3_SW: begin
          legal      = 1'b1;
          wdata      = data;
          wstrb      = NB'(4'hF);
          misaligned = |addr[1:0];
        end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/store_queue.sv
// Store buffer: formats legal stores, holds them in FIFO order and drains
// them to data memory; also flags loads that alias a buffered word.
module store_queue
  import store_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  store_req_if.slave      req,
  store_mem_if.master     mem,
  input  logic [XLEN-1:0] ld_addr,
  output logic            ld_hit,
  output logic            empty
);

  localparam int NB = XLEN / 8;
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] fmt_wdata;
  logic [NB-1:0]   fmt_wstrb;
  logic            fmt_legal;
  logic            fmt_misaligned;

  sq_entry_t       entries_q [DEPTH];
  sq_entry_t       entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;

  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  sq_entry_t       head;

  store_format #(.XLEN(XLEN)) u_format (
    .opcode     (req.opcode),
    .funct3     (req.funct3),
    .addr       (req.st_addr),
    .data       (req.st_data),
    .wdata      (fmt_wdata),
    .wstrb      (fmt_wstrb),
    .legal      (fmt_legal),
    .misaligned (fmt_misaligned)
  );

  // Handshake, occupancy and memory-facing view of the head entry.
  always_comb begin
    full          = &valid_q;
    empty         = ~|valid_q;
    req.st_ready  = rst_n && !full;
    req.st_err    = err_q;
    accept        = req.st_valid && req.st_ready;
    push          = accept && fmt_legal && !fmt_misaligned;
    head          = entries_q[rd_ptr_q];
    mem.mem_valid = !empty;
    pop           = mem.mem_valid && mem.mem_ready;
    mem.mem_addr  = XLEN'(head.addr);
    mem.mem_wdata = XLEN'(head.wdata);
    mem.mem_wstrb = mem.mem_valid ? NB'(head.wstrb) : '0;
  end

  // Next-state for the ring: pop frees the head slot, push fills the tail slot.
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = accept && (!fmt_legal || fmt_misaligned);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q]         = 1'b1;
      entries_d[wr_ptr_q].addr  = ENTRY_XLEN'({req.st_addr[XLEN-1:2], 2'b00});
      entries_d[wr_ptr_q].wdata = ENTRY_XLEN'(fmt_wdata);
      entries_d[wr_ptr_q].wstrb = ENTRY_NB'(fmt_wstrb);
      wr_ptr_d                  = wr_ptr_q + 1'b1;
    end
  end

  // Load aliasing: compare word addresses of every occupied slot.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (((XLEN'(entries_q[i].addr) ^ ld_addr) >> 2) == '0)) begin
        ld_hit = 1'b1;
      end
    end
  end

  // Control state; reset drops any buffered entries, even one mid-transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Entry payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_store_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [6:0] OPC_ST = 7'h23;
  localparam logic [6:0] OPC_LD = 7'h03;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } ent_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        empty;

  store_req_if #(.XLEN(XLEN)) req_if ();
  store_mem_if #(.XLEN(XLEN)) mem_if ();

  store_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_if),
    .mem     (mem_if),
    .ld_addr (ld_addr),
    .ld_hit  (ld_hit),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  ent_t mq[$];
  bit   exp_err = 1'b0;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference formatting from the instruction rules, using plain arithmetic.
  function automatic void model_fmt(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] d,
                                    output bit ok, output ent_t e);
    ok      = 1'b0;
    e.addr  = a & ~32'd3;
    e.wdata = 32'd0;
    e.strb  = 4'd0;
    if (op == OPC_ST) begin
      if (f3 == 3'd0) begin
        ok      = 1'b1;
        e.wdata = (d & 32'hFF) * 32'h01010101;
        e.strb  = 4'(1 << (a % 4));
      end else if (f3 == 3'd1 && (a % 2) == 0) begin
        ok      = 1'b1;
        e.wdata = (d & 32'hFFFF) * 32'h00010001;
        e.strb  = 4'(3 << (a & 2));
      end else if (f3 == 3'd2 && (a % 4) == 0) begin
        ok      = 1'b1;
        e.wdata = d;
        e.strb  = 4'hF;
      end
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] la);
    foreach (mq[i]) if ((mq[i].addr >> 2) == (la >> 2)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic mr,
                       input logic [31:0] la, input logic rn);
    req_if.st_valid  = v;
    req_if.opcode    = op;
    req_if.funct3    = f3;
    req_if.st_addr   = a;
    req_if.st_data   = d;
    mem_if.mem_ready = mr;
    ld_addr          = la;
    rst_n            = rn;
  endtask

  task automatic settle_check();
    @(negedge clk);
    chk("st_ready", 32'(req_if.st_ready), 32'(rst_n && (mq.size() < DEPTH)));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("mem_valid", 32'(mem_if.mem_valid), 32'(mq.size() != 0));
    chk("st_err", 32'(req_if.st_err), 32'(exp_err));
    chk("ld_hit", 32'(ld_hit), 32'(model_hit(ld_addr)));
    if (mq.size() == 0) begin
      chk("wstrb_idle", 32'(mem_if.mem_wstrb), 32'd0);
    end else begin
      chk("mem_addr", mem_if.mem_addr, mq[0].addr);
      chk("mem_wdata", mem_if.mem_wdata, mq[0].wdata);
      chk("mem_wstrb", 32'(mem_if.mem_wstrb), 32'(mq[0].strb));
    end
  endtask

  task automatic advance();
    bit   ok;
    bit   acc;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      exp_err = 1'b0;
    end else begin
      acc = req_if.st_valid && (mq.size() < DEPTH);
      model_fmt(req_if.opcode, req_if.funct3, req_if.st_addr, req_if.st_data, ok, e);
      exp_err = acc && !ok;
      if (mq.size() != 0 && mem_if.mem_ready) void'(mq.pop_front());
      if (acc && ok) mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    vecs[0] = '{OPC_ST, 3'b010, 32'h2000, 32'h5C3D5467, 1'b0, 32'h2000, 32'h5C3D5467, 4'hF};
    vecs[1] = '{OPC_ST, 3'b000, 32'h1001, 32'h5C3D5467, 1'b0, 32'h1000, 32'h67676767, 4'h2};
    vecs[2] = '{OPC_ST, 3'b000, 32'h1003, 32'h000000AB, 1'b0, 32'h1000, 32'hABABABAB, 4'h8};
    vecs[3] = '{OPC_ST, 3'b001, 32'h1002, 32'h1234BEEF, 1'b0, 32'h1000, 32'hBEEFBEEF, 4'hC};
    vecs[4] = '{OPC_ST, 3'b001, 32'h1000, 32'hCAFE1234, 1'b0, 32'h1000, 32'h12341234, 4'h3};
    vecs[5] = '{OPC_ST, 3'b001, 32'h1003, 32'h11112222, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[6] = '{OPC_ST, 3'b011, 32'h1000, 32'h11112222, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[7] = '{OPC_ST, 3'b010, 32'h2002, 32'h11112222, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[8] = '{OPC_LD, 3'b010, 32'h2000, 32'h11112222, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[9] = '{OPC_ST, 3'b000, 32'h4000, 32'h11223380, 1'b0, 32'h4000, 32'h80808080, 4'h1};

    // Reset: first edge brings the DUT to a known state, second is checked.
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    advance();
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    settle_check();
    chk("rst_ready_low", 32'(req_if.st_ready), 32'd0);
    advance();
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    settle_check();
    chk("ready_after_rst", 32'(req_if.st_ready), 32'd1);
    advance();

    // Directed vector table, each on an empty queue with memory ready.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].data, 1'b1, 32'h0, 1'b1);
      settle_check();
      advance();
      drive(1'b0, OPC_ST, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
      settle_check();
      chk($sformatf("vec%0d_err", i), 32'(req_if.st_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_valid", i), 32'(mem_if.mem_valid), 32'(!vecs[i].err));
      if (!vecs[i].err) begin
        chk($sformatf("vec%0d_addr", i), mem_if.mem_addr, vecs[i].maddr);
        chk($sformatf("vec%0d_wdata", i), mem_if.mem_wdata, vecs[i].wdata);
        chk($sformatf("vec%0d_wstrb", i), 32'(mem_if.mem_wstrb), 32'(vecs[i].strb));
      end
      advance();
      drive(1'b0, OPC_ST, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
      settle_check();
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'd1);
      chk($sformatf("vec%0d_err_clr", i), 32'(req_if.st_err), 32'd0);
      advance();
    end

    // Fill to capacity with memory stalled, hold a fifth, then drain.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, OPC_ST, 3'b010, 32'h5000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 32'h0, 1'b1);
      settle_check();
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, OPC_ST, 3'b010, 32'h5010, 32'hA4, 1'b0, 32'h0, 1'b1);
      settle_check();
      chk("full_ready_low", 32'(req_if.st_ready), 32'd0);
      chk("full_head", mem_if.mem_addr, 32'h5000);
      advance();
    end
    drive(1'b1, OPC_ST, 3'b010, 32'h5010, 32'hA4, 1'b1, 32'h0, 1'b1);
    settle_check();
    chk("release_ready_low", 32'(req_if.st_ready), 32'd0);
    advance();
    drive(1'b1, OPC_ST, 3'b010, 32'h5010, 32'hA4, 1'b1, 32'h0, 1'b1);
    settle_check();
    chk("pushpop_ready", 32'(req_if.st_ready), 32'd1);
    chk("pushpop_head", mem_if.mem_addr, 32'h5004);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
      settle_check();
      chk($sformatf("drain%0d_addr", i), mem_if.mem_addr, 32'h5008 + 32'(4 * i));
      chk($sformatf("drain%0d_ready", i), 32'(req_if.st_ready), 32'd1);
      advance();
    end
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    settle_check();
    chk("drained_empty", 32'(empty), 32'd1);
    advance();

    // Load aliasing, then reset with entries buffered.
    drive(1'b1, OPC_ST, 3'b010, 32'h3000, 32'h12345678, 1'b0, 32'h3002, 1'b1);
    settle_check();
    advance();
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b0, 32'h3002, 1'b1);
    settle_check();
    chk("ld_hit_3002", 32'(ld_hit), 32'd1);
    advance();
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b0, 32'h3004, 1'b1);
    settle_check();
    chk("ld_hit_3004", 32'(ld_hit), 32'd0);
    advance();
    for (int i = 1; i < 3; i++) begin
      drive(1'b1, OPC_ST, 3'b000, 32'h3100 + 32'(i), 32'h55, 1'b0, 32'h3004, 1'b1);
      settle_check();
      advance();
    end
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b1, 32'h3000, 1'b0);
    settle_check();
    advance();
    drive(1'b0, OPC_ST, 3'b010, 32'h0, 32'h0, 1'b1, 32'h3000, 1'b1);
    settle_check();
    chk("rst3_empty", 32'(empty), 32'd1);
    chk("rst3_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    chk("rst3_ld_hit", 32'(ld_hit), 32'd0);
    advance();

    // Randomized traffic in a narrow address window so aliasing is frequent.
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? OPC_LD : OPC_ST,
            3'($urandom_range(0, 3)),
            32'h100 + 32'($urandom_range(0, 31)),
            $urandom,
            ($urandom_range(0, 2) == 0),
            32'h100 + 32'($urandom_range(0, 31)),
            ($urandom_range(0, 199) != 0));
      settle_check();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of buffered stores (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port st_valid  input  1  pipeline presents a store request.
REQ-006 SHALL have port st_ready  output  1  queue can accept a request this cycle.
REQ-007 SHALL have port opcode  input  7  instruction opcode.
REQ-008 SHALL have port funct3  input  3  store width select.
REQ-009 SHALL have port st_addr  input  XLEN  byte address.
REQ-010 SHALL have port st_data  input  XLEN  unformatted rs2 data.
REQ-011 SHALL have port st_err  output  1  one-cycle pulse: rejected request (illegal or misaligned).
REQ-012 SHALL have port mem_valid  output  1  head entry presented to data memory.
REQ-013 SHALL have port mem_ready  input  1  data memory accepts head entry.
REQ-014 SHALL have port mem_addr  output  XLEN  word-aligned address (low 2 bits zero).
REQ-015 SHALL have port mem_wdata  output  XLEN  lane-formatted write data.
REQ-016 SHALL have port mem_wstrb  output  XLEN/8  byte-lane strobes.
REQ-017 SHALL have port ld_addr  input  XLEN  address of a load in flight.
REQ-018 SHALL have port ld_hit  output  1  buffered store targets the same word as ld_addr.
REQ-019 SHALL have port empty  output  1  no buffered entries.

Function
REQ-020 SHALL accept a request on a rising edge where st_valid and st_ready are both high; st_ready = not full (no full-queue bypass).
REQ-021 SHALL treat only opcode 0100011 with funct3 000 (SB), 001 (SH), 010 (SW) as legal; anything else accepted by handshake SHALL be discarded and raise st_err next cycle.
REQ-022 SB: wdata = byte 0 of st_data replicated to all lanes; wstrb = 0001 shifted left by st_addr[1:0].
REQ-023 SH: wdata = low halfword replicated; wstrb = 0011 shifted by 2*st_addr[1]; st_addr[0]=1 is misaligned.
REQ-024 SW: wdata = st_data; wstrb = 1111; st_addr[1:0]!=0 is misaligned.
REQ-025 Misaligned requests SHALL be discarded, raise st_err next cycle, not alter queue state.
REQ-026 Legal entries SHALL be stored in FIFO order; a stored entry appears on mem_* no earlier than the cycle after acceptance (1-cycle latency when empty).
REQ-027 mem_valid SHALL equal not empty; mem_addr/wdata/wstrb SHALL be stable while mem_valid high and mem_ready low.
REQ-028 Head SHALL be popped on a rising edge with mem_valid and mem_ready high.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-030 ld_hit SHALL be combinational: high when any valid entry's word address equals ld_addr with low 2 bits ignored; low when empty.
REQ-031 mem_wstrb SHALL be all zero when mem_valid low.

Reset
REQ-032 While rst_n low at a clock edge: pointers and occupancy 0, empty=1, mem_valid=0, st_err=0, st_ready=0 during reset cycle; buffered entries discarded even mid-transfer.
REQ-033 st_ready SHALL be 1 from the first cycle after rst_n returns high.

Structure
REQ-034 Package store_pkg SHALL hold STORE opcode constant, funct3 encodings SB/SH/SW, and the entry struct (addr, wdata, wstrb).
REQ-035 A combinational sub-module store_format SHALL produce wdata, wstrb, legal, misaligned from opcode, funct3, addr, data.

Verification
REQ-036 SW 0x5C3D5467 to 0x2000, mem_ready=1 -> next cycle mem_addr 0x2000, wdata 0x5C3D5467, wstrb 1111, then empty.
REQ-037 SB 0x5C3D5467 to 0x1001 -> mem_addr 0x1000, wdata 0x67676767, wstrb 0010.
REQ-038 SH to 0x1003 -> st_err pulse one cycle, empty stays 1; funct3 011 -> st_err, nothing enqueued.
REQ-039 mem_ready=0, push DEPTH stores -> st_ready low after 4th; fifth held; release mem_ready -> FIFO order drains, push+pop same cycle keeps count.
REQ-040 Buffered SW at 0x3000, ld_addr 0x3002 -> ld_hit=1; ld_addr 0x3004 -> 0; rst_n low with 3 entries -> empty=1, mem_valid=0 next cycle.
